// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - phase codes, encoding widths and width helper for the match sequencer
package match_pkg;

  localparam logic [2:0] CODE_IDLE       = 3'd0;
  localparam logic [2:0] CODE_COUNTDOWN  = 3'd1;
  localparam logic [2:0] CODE_FIGHT      = 3'd2;
  localparam logic [2:0] CODE_ROUND_OVER = 3'd3;
  localparam logic [2:0] CODE_MATCH_OVER = 3'd4;
  localparam logic [2:0] CODE_PAUSED     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = CODE_IDLE,
    S_COUNTDOWN  = CODE_COUNTDOWN,
    S_FIGHT      = CODE_FIGHT,
    S_ROUND_OVER = CODE_ROUND_OVER,
    S_MATCH_OVER = CODE_MATCH_OVER,
    S_PAUSED     = CODE_PAUSED
  } state_t;

  localparam int WINNER_W = 3;
  localparam int WINS_W   = 3;
  localparam logic [WINS_W-1:0] WINS_MAX = '1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/match_controller_second_ticker.sv
// rtl/match_controller_second_ticker.sv - game-second tick generator, restarts on every phase entry
module second_ticker
  import match_pkg::*;
#(
  parameter int TICKS_PER_S = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int CW = cnt_width(TICKS_PER_S);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_S - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Tick on the wrap cycle, so the first one lands TICKS_PER_S cycles after a clear.
  assign tick = (cnt == LAST) && !freeze;

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - best-of-N round/match sequencer; MATCH_PAUSE_EN adds a PAUSED phase
module match_controller
  import match_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int HEALTH_W      = 3,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int TICKS_PER_S   = 60,
  parameter int COUNTDOWN_S   = 3,
  parameter int ROUND_TIME_S  = 60,
  parameter int HOLD_S        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            pause,
  input  logic [NUM_PLAYERS*HEALTH_W-1:0] health_flat,
  output logic [2:0]                      game_state,
  output logic [3:0]                      countdown,
  output logic [7:0]                      time_left,
  output logic [NUM_PLAYERS*WINS_W-1:0]   wins_flat,
  output logic [WINNER_W-1:0]             round_winner,
  output logic [WINNER_W-1:0]             match_winner,
  output logic                            round_rst
);

  localparam int HOLD_W = cnt_width(HOLD_S);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_S - 1);

  state_t state, state_next;
  logic start_r, start_r2, start_rise, pause_rise, tick;
  logic ticker_clear, ticker_freeze, round_rst_next;
  logic new_match, round_end, credit, cd_dec, time_dec, hold_inc, match_end;
  logic [2:0] win_idx, alive_cnt, alive_idx, max_cnt, max_idx, match_idx;
  logic [WINNER_W-1:0] round_code;
  logic [HEALTH_W-1:0] h, max_h;
  logic match_found;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WINS_W-1:0] wins [NUM_PLAYERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r  <= 1'b0;
      start_r2 <= 1'b0;
    end else begin
      start_r  <= start;
      start_r2 <= start_r;
    end
  end
  assign start_rise = start_r & ~start_r2;

`ifdef MATCH_PAUSE_EN
  logic pause_r, pause_r2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_r  <= 1'b0;
      pause_r2 <= 1'b0;
    end else begin
      pause_r  <= pause;
      pause_r2 <= pause_r;
    end
  end
  assign pause_rise = pause_r & ~pause_r2;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_rise   = 1'b0;
`endif

  // Alive count and unique-highest-health search over all players.
  always_comb begin
    alive_cnt = '0;
    alive_idx = '0;
    max_h     = '0;
    max_cnt   = '0;
    max_idx   = '0;
    h         = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      h = health_flat[k*HEALTH_W +: HEALTH_W];
      if (h != '0) begin
        alive_cnt = alive_cnt + 3'd1;
        alive_idx = 3'(k);
      end
      if (h > max_h) begin
        max_h   = h;
        max_cnt = 3'd1;
        max_idx = 3'(k);
      end else if (h == max_h) begin
        max_cnt = max_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (!match_found && wins[k] == WINS_W'(ROUNDS_TO_WIN)) begin
        match_found = 1'b1;
        match_idx   = 3'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    new_match  = 1'b0;
    round_end  = 1'b0;
    credit     = 1'b0;
    win_idx    = '0;
    round_code = '0;
    cd_dec     = 1'b0;
    time_dec   = 1'b0;
    hold_inc   = 1'b0;
    match_end  = 1'b0;
    case (state)
      S_IDLE, S_MATCH_OVER: begin
        if (start_rise) begin
          state_next = S_COUNTDOWN;
          new_match  = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (countdown == 4'd1) state_next = S_FIGHT;
          else                   cd_dec     = 1'b1;
        end
      end
      S_FIGHT: begin
        if (pause_rise) begin
          state_next = S_PAUSED;
        end else begin
          time_dec = tick;
          // KO outcomes take precedence over a simultaneous timeout.
          if (alive_cnt == 3'd1) begin
            round_end = 1'b1;
            credit    = 1'b1;
            win_idx   = alive_idx;
          end else if (alive_cnt == 3'd0) begin
            round_end = 1'b1;
          end else if (tick && time_left == 8'd1) begin
            round_end = 1'b1;
            credit    = (max_cnt == 3'd1);
            win_idx   = max_idx;
          end
          if (round_end) begin
            state_next = S_ROUND_OVER;
            if (credit) round_code = WINNER_W'(win_idx) + WINNER_W'(1);
          end
        end
      end
      S_ROUND_OVER: begin
        if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            if (match_found) begin
              state_next = S_MATCH_OVER;
              match_end  = 1'b1;
            end else begin
              state_next = S_COUNTDOWN;
            end
          end else begin
            hold_inc = 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (pause_rise) state_next = S_FIGHT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign round_rst_next = (state_next == S_COUNTDOWN) && (state != S_COUNTDOWN);
  // Pause transitions keep the sub-second phase so resuming does not lose time.
  assign ticker_clear  = (state_next != state) && (state != S_PAUSED) && (state_next != S_PAUSED);
  assign ticker_freeze = (state == S_PAUSED) || (state_next == S_PAUSED);

  second_ticker #(.TICKS_PER_S(TICKS_PER_S)) u_ticker (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ticker_clear),
    .freeze (ticker_freeze),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countdown    <= '0;
      time_left    <= '0;
      round_winner <= '0;
      match_winner <= '0;
      round_rst    <= 1'b0;
      hold_cnt     <= '0;
      for (int k = 0; k < NUM_PLAYERS; k++) wins[k] <= '0;
    end else begin
      round_rst <= round_rst_next;
      if (round_rst_next) begin
        countdown <= 4'(COUNTDOWN_S);
      end else if (cd_dec) begin
        countdown <= countdown - 4'd1;
      end else if (state == S_COUNTDOWN && state_next == S_FIGHT) begin
        countdown <= '0;
        time_left <= 8'(ROUND_TIME_S);
      end
      if (time_dec) time_left <= time_left - 8'd1;
      if (round_end)     hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + HOLD_W'(1);
      if (new_match) begin
        round_winner <= '0;
        match_winner <= '0;
      end else if (round_end) begin
        round_winner <= round_code;
      end
      if (match_end) match_winner <= WINNER_W'(match_idx) + WINNER_W'(1);
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        if (new_match)
          wins[k] <= '0;
        else if (round_end && credit && win_idx == 3'(k) && wins[k] != WINS_MAX)
          wins[k] <= wins[k] + WINS_W'(1);
      end
    end
  end

  always_comb begin
    wins_flat = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) wins_flat[k*WINS_W +: WINS_W] = wins[k];
  end

  assign game_state = state;

endmodule

// File: doc/match_controller.md
# match_controller

Parametrised match/round sequencer that replaces the fixed single-round game-state logic. Runs on the 60 Hz effective frame clock beside the player, health and hit-detect blocks. Sequences countdown, fight, round-over and match-over phases for 2–4 players, keeps per-player round wins for a best-of-N match, and pulses a round reset to the player and health blocks. Its `game_state` output drives the display, LED and reset-gating logic.

## Interface
- `NUM_PLAYERS`, 2: players tracked, 2..4.
- `HEALTH_W`, 3: per-player health width.
- `ROUNDS_TO_WIN`, 2: round wins that end the match, 1..7.
- `TICKS_PER_S`, 60: clock ticks per game second, ≥2.
- `COUNTDOWN_S`, 3: pre-fight countdown in seconds, 1..15.
- `ROUND_TIME_S`, 60: fight time limit in seconds, 1..255.
- `HOLD_S`, 2: round-over display hold in seconds, ≥1.
- `clk`  in  1  frame clock (effective clock).
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level; any player key pressed.
- `pause`  in  1  level pause request; used only with `MATCH_PAUSE_EN`.
- `health_flat`  in  NUM_PLAYERS*HEALTH_W  player k health at bits [k*HEALTH_W +: HEALTH_W].
- `game_state`  out  3  current phase code.
- `countdown`  out  4  seconds left in COUNTDOWN, else 0.
- `time_left`  out  8  fight seconds remaining.
- `wins_flat`  out  NUM_PLAYERS*3  per-player round wins.
- `round_winner`  out  3  winner of the last round, 1-based; 0 means draw or none.
- `match_winner`  out  3  match winner, 1-based; 0 means none.
- `round_rst`  out  1  one-cycle pulse that restarts player positions and health.

## Operation
- States and codes: IDLE=0, COUNTDOWN=1, FIGHT=2, ROUND_OVER=3, MATCH_OVER=4, PAUSED=5 (PAUSED exists only with the macro).
- `start` is registered and rising-edge detected. `start_rise` means the cycle after a 0→1 transition.
- IDLE: on `start_rise`, clear all wins and both winner outputs, pulse `round_rst`, go to COUNTDOWN.
- COUNTDOWN: load `countdown`=COUNTDOWN_S on entry and decrement on each second tick.
  - When the tick would take it from 1 to 0, go to FIGHT with `time_left`=ROUND_TIME_S.
- FIGHT: decrement `time_left` on each second tick. Player k is alive when its health ≠ 0. Evaluate every cycle, in this order:
  1. Exactly one player alive: that player wins the round.
  2. Zero players alive: the round is a draw.
  3. The tick would make `time_left` 0: the unique highest health wins; a tie for highest is a draw.
  - Any outcome sets `round_winner`, increments the winner's wins (saturating at 7), and moves to ROUND_OVER.
- ROUND_OVER: hold for HOLD_S seconds.
  - If any wins count equals ROUNDS_TO_WIN: set `match_winner` and go to MATCH_OVER.
  - Otherwise pulse `round_rst` and go to COUNTDOWN.
- MATCH_OVER: hold all outputs. On `start_rise`, behave as in IDLE (new match).
- Second tick: internal counter 0..TICKS_PER_S-1. It is cleared on every state entry. The tick fires on wrap, so the first tick comes TICKS_PER_S cycles after entry.

## Timing
- Reset values: `game_state`=IDLE, `countdown`=0, `time_left`=0, wins=0, `round_winner`=0, `match_winner`=0, `round_rst`=0, tick counter=0.
- All outputs are registered and change one cycle after the deciding condition.
- `round_rst` is high for exactly the first cycle in COUNTDOWN.
- Health is sampled in FIGHT only. A KO and a timeout in the same cycle resolve as the KO.
- Asserting reset mid-round returns to IDLE immediately, with no win credited.

## Configuration
- `MATCH_PAUSE_EN` defined:
  - In FIGHT, a rising edge of `pause` enters PAUSED.
  - PAUSED freezes the tick counter, `time_left` and KO evaluation.
  - The next rising edge of `pause` returns to FIGHT with the tick counter preserved.
- `MATCH_PAUSE_EN` undefined: `pause` is ignored and state code 5 is never produced.

## Structure
- `match_pkg` holds the state code localparams, the winner-encoding width, and the width-derivation function.
- One sub-module, `second_ticker`, owns the TICKS_PER_S counter. Ports: `clk`, `rst_n`, `clear`, `freeze`, `tick`.
- The FSM, the alive/highest-health reduction over NUM_PLAYERS, and the win counters live in `match_controller`.

## Test plan
Bench parameters: NUM_PLAYERS=2, TICKS_PER_S=4, COUNTDOWN_S=3, ROUND_TIME_S=5, HOLD_S=2, ROUNDS_TO_WIN=2.
- Start from reset: pulse `start` with health 7/7 → `round_rst` high 1 cycle; `countdown` shows 3,2,1, 4 cycles each; then FIGHT with `time_left`=5.
- KO: drive P2 health to 0 in FIGHT → next cycle ROUND_OVER, `round_winner`=1, P1 wins=1; after 8 cycles COUNTDOWN with a `round_rst` pulse.
- Timeout: hold health 5/3 with no KO → after 20 FIGHT cycles `round_winner`=1. Repeat with 4/4 → `round_winner`=0 and no win credited.
- Double KO: both health go to 0 in the same cycle → draw, wins unchanged.
- Match end: P2 wins two rounds → MATCH_OVER, `match_winner`=2. Then `start` → wins cleared, COUNTDOWN.
- With `MATCH_PAUSE_EN`: pulse `pause` at `time_left`=3 → state 5; hold 50 cycles with P1 health forced to 0 → no change; pulse `pause` again → FIGHT, `time_left`=3, then KO resolves.
